hilo_muldiv_ctrl: RTL and testbench

Owns the architectural HI/LO register pair and sequences multi-cycle MULT/MULTU/DIV/DIVU for the EX stage. It also serves single-cycle MTHI/MTLO/MFHI/MFLO accesses. A long operation raises a stall to the pipeline until it retires. A flush from the exception unit cancels an in-flight operation without disturbing HI/LO.

---
 rtl/hilo_muldiv_ctrl_if.sv | 23 ++
 rtl/hilo_muldiv_ctrl.sv | 156 +++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_ctrl_if.sv
// rtl/hilo_muldiv_ctrl_if.sv - EX-stage bundle between the pipeline and the HI/LO mul/div controller
interface hilo_muldiv_ctrl_if;
    logic        op_valid;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        stall;
    logic        busy;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output op_valid, op, rs_val, rt_val, flush,
        input  stall, busy, rdata, hi, lo
    );

    modport slave (
        input  op_valid, op, rs_val, rt_val, flush,
        output stall, busy, rdata, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - HI/LO register pair with multi-cycle MULT/MULTU/DIV/DIVU sequencing
module hilo_muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    hilo_muldiv_ctrl_if.slave bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam logic [4:0] MUL_CNT  = 5'(MUL_LAT - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic        sgn_q, sgn_d;

    logic        issue;
    logic        signed_op;
    logic [31:0] abs_rs, abs_rt;
    logic        a_neg, b_neg;
    logic [63:0] product;
    logic [32:0] shifted;
    logic        q_bit;
    logic [31:0] rem_step, quo_step, q_fin, r_fin;
    logic [31:0] rdata_c;

    assign issue     = (state_q == IDLE) && bus.op_valid && !bus.flush &&
                       (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);
    assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign abs_rs    = (signed_op && bus.rs_val[31]) ? -bus.rs_val : bus.rs_val;
    assign abs_rt    = (signed_op && bus.rt_val[31]) ? -bus.rt_val : bus.rt_val;

    assign a_neg   = sgn_q & a_q[31];
    assign b_neg   = sgn_q & b_q[31];
    // Sign/zero extension to 64 bits makes one unsigned multiply serve both MULT and MULTU.
    assign product = {{32{a_neg}}, a_q} * {{32{b_neg}}, b_q};

    // Restoring step: the subtraction is taken only when it cannot go negative.
    assign shifted  = {rem_q, quo_q[31]};
    assign q_bit    = shifted >= {1'b0, dvs_q};
    assign rem_step = q_bit ? (shifted[31:0] - dvs_q) : shifted[31:0];
    assign quo_step = {quo_q[30:0], q_bit};
    assign q_fin    = (a_neg ^ b_neg) ? -quo_step : quo_step;
    assign r_fin    = a_neg ? -rem_step : rem_step;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        sgn_d   = sgn_q;
        rdata_c = 32'd0;
        if (state_q == IDLE) begin
            if (bus.op_valid && !bus.flush) begin
                case (bus.op)
                    OP_MULT, OP_MULTU: begin
                        state_d = MUL;
                        cnt_d   = MUL_CNT;
                        a_d     = bus.rs_val;
                        b_d     = bus.rt_val;
                        sgn_d   = signed_op;
                    end
                    OP_DIV, OP_DIVU: begin
                        state_d = DIV;
                        cnt_d   = 5'd31;
                        a_d     = bus.rs_val;
                        b_d     = bus.rt_val;
                        sgn_d   = signed_op;
                        rem_d   = 32'd0;
                        quo_d   = abs_rs;
                        dvs_d   = abs_rt;
                    end
                    OP_MTHI: hi_d    = bus.rs_val;
                    OP_MTLO: lo_d    = bus.rs_val;
                    OP_MFHI: rdata_c = hi_q;
                    OP_MFLO: rdata_c = lo_q;
                    default: ;
                endcase
            end
        end else if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = 5'd0;
        end else if (state_q == MUL) begin
            if (cnt_q == 5'd0) begin
                state_d = IDLE;
                hi_d    = product[63:32];
                lo_d    = product[31:0];
            end else begin
                cnt_d = cnt_q - 5'd1;
            end
        end else begin
            rem_d = rem_step;
            quo_d = quo_step;
            if (cnt_q == 5'd0) begin
                state_d = IDLE;
                if (b_q == 32'd0) begin
                    hi_d = a_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = r_fin;
                    lo_d = q_fin;
                end
            end else begin
                cnt_d = cnt_q - 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            sgn_q   <= sgn_d;
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.stall = !bus.flush && (issue || ((state_q != IDLE) && (cnt_q != 5'd0)));
    assign bus.rdata = rdata_c;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb/tb_hilo_muldiv_ctrl.sv - randomized self-checking bench for hilo_muldiv_ctrl
module tb_hilo_muldiv_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    hilo_muldiv_ctrl_if bus ();

    hilo_muldiv_ctrl #(.MUL_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd1: return 64'(sa * sb);
            4'd2: return ua * ub;
            4'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Presents a long op, keeps it presented (with garbage operands) while stalled, returns the stall count.
    task automatic run_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
        logic [63:0] r;
        n = 0;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.rs_val   = a;
        bus.rt_val   = b;
        bus.flush    = 1'b0;
        #1;
        while (bus.stall && n < 100) begin
            n++;
            @(negedge clk);
            bus.rs_val = $urandom;
            bus.rt_val = $urandom;
            #1;
        end
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.op       = 4'd0;
        r = model(op, a, b);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        #1;
    endtask

    task automatic drive_short(input logic [3:0] op, input logic [31:0] a);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.rs_val   = a;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
        total++; if (bus.lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic check_long(input string name, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input int lat);
        int n;
        run_long(op, a, b, n);
        total++; if (n != lat) begin bad++; $display("FAIL %s_stall got=%0d exp=%0d", name, n, lat); end
        total++; if (bus.hi !== exp_hi) begin bad++; $display("FAIL %s_hi got=%h exp=%h", name, bus.hi, exp_hi); end
        total++; if (bus.lo !== exp_lo) begin bad++; $display("FAIL %s_lo got=%h exp=%h", name, bus.lo, exp_lo); end
    endtask

    task automatic test_directed();
        check_long("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 2);
        total++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin bad++; $display("FAIL mult_const got=%h exp=FFFFFFFFFFFFFFFA", {bus.hi, bus.lo}); end
        check_long("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 2);
        bus.op_valid = 1'b1;
        bus.op       = 4'd7;
        #1;
        total++; if (bus.rdata !== 32'h0000_0002) begin bad++; $display("FAIL multu_mfhi got=%h exp=00000002", bus.rdata); end
        @(negedge clk);
        bus.op_valid = 1'b0;
        check_long("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 32);
        total++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL div_neg_const got=%h exp=FFFFFFFFFFFFFFFD", {bus.hi, bus.lo}); end
        check_long("divu", 4'd4, 32'd7, 32'd2, 32);
        check_long("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32);
        total++; if (bus.lo !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_const got=%h exp=80000000", bus.lo); end
        check_long("divu_zero", 4'd4, 32'd5, 32'd0, 32);
        check_long("div_zero", 4'd3, 32'h8000_0005, 32'd0, 32);
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, b, v;
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(1, 4));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            check_long("rand_long", op, a, b, (op <= 4'd2) ? 2 : 32);
        end
        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                drive_short(4'd5, v);
                exp_hi = v;
            end else begin
                drive_short(4'd6, v);
                exp_lo = v;
            end
            total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rand_mt_stall got=%b exp=0", bus.stall); end
            drive_short(4'd7, 32'd0);
            total++; if (bus.rdata !== exp_hi) begin bad++; $display("FAIL rand_mfhi got=%h exp=%h", bus.rdata, exp_hi); end
            drive_short(4'd8, 32'd0);
            total++; if (bus.rdata !== exp_lo) begin bad++; $display("FAIL rand_mflo got=%h exp=%h", bus.rdata, exp_lo); end
        end
        @(negedge clk);
        bus.op_valid = 1'b0;
    endtask

    task automatic test_flush_div();
        drive_short(4'd6, 32'h1234_5678);
        exp_lo = 32'h1234_5678;
        @(negedge clk);
        bus.op     = 4'd4;
        bus.rs_val = 32'd100;
        bus.rt_val = 32'd7;
        #1;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL flush_issue_stall got=%b exp=1", bus.stall); end
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            bus.op = (k == 3) ? 4'd7 : 4'd4;
            #1;
            if (k == 3) begin
                total++; if (bus.rdata !== 32'd0) begin bad++; $display("FAIL busy_rdata got=%h exp=0", bus.rdata); end
            end
        end
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", bus.stall); end
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.op_valid = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", bus.busy); end
        total++; if (bus.hi !== exp_hi) begin bad++; $display("FAIL flush_hi got=%h exp=%h", bus.hi, exp_hi); end
        drive_short(4'd8, 32'd0);
        total++; if (bus.rdata !== 32'h1234_5678) begin bad++; $display("FAIL flush_mflo got=%h exp=12345678", bus.rdata); end
        @(negedge clk);
        bus.op_valid = 1'b0;
    endtask

    task automatic test_flush_idle();
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = 4'd5;
        bus.rs_val   = 32'h55;
        bus.flush    = 1'b1;
        #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL flush_idle_stall got=%b exp=0", bus.stall); end
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.op_valid = 1'b0;
        #1;
        total++; if (bus.hi !== exp_hi) begin bad++; $display("FAIL flush_idle_hi got=%h exp=%h", bus.hi, exp_hi); end
    endtask

    task automatic test_back_to_back();
        drive_short(4'd5, 32'hDEAD_BEEF);
        drive_short(4'd7, 32'd0);
        total++; if (bus.rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL b2b_mfhi got=%h exp=DEADBEEF", bus.rdata); end
        exp_hi = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.op_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive_short(4'd5, 32'hAA);
        @(negedge clk);
        bus.op     = 4'd1;
        bus.rs_val = 32'd9;
        bus.rt_val = 32'd9;
        @(negedge clk);
        bus.op     = 4'd4;
        bus.rt_val = 32'd3;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.op_valid = 1'b0;
        #1;
        total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL rstmid_hi got=%h exp=0", bus.hi); end
        total++; if (bus.lo !== 32'd0) begin bad++; $display("FAIL rstmid_lo got=%h exp=0", bus.lo); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rstmid_stall got=%b exp=0", bus.stall); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    endtask

    initial begin
        bus.op_valid = 1'b0;
        bus.op       = 4'd0;
        bus.rs_val   = 32'd0;
        bus.rt_val   = 32'd0;
        bus.flush    = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_flush_div();
        test_flush_idle();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
